// File: rtl/tsc_multicycle_ctrl.sv
// Multi-cycle FETCH/DECODE/EXEC/WB controller for the TSC subset (ADD, ADI, LHI, WWD, JMP, HLT).
// Optional macro INST_COUNT_EN adds the num_inst retired-instruction counter port.
module tsc_multicycle_ctrl #(
   parameter int OPC_W  = 4,
   parameter int FUNC_W = 6,
   parameter int CNT_W  = 16
) (
   input  logic              clk,
   input  logic              reset_cpu,
   input  logic              cpu_enable,
   input  logic              wwd_enable,
   input  logic [OPC_W-1:0]  opcode,
   input  logic [FUNC_W-1:0] func,
   output logic              ir_write,
   output logic              pc_write,
   output logic              pc_src_jump,
   output logic              reg_write,
   output logic              reg_dst_rd,
   output logic              alu_src_imm,
   output logic [1:0]        alu_op,
   output logic              output_port_write,
   output logic              halted,
   output logic              illegal,
   output logic [2:0]        state
`ifdef INST_COUNT_EN
   ,
   output logic [CNT_W-1:0]  num_inst
`endif
);

   typedef enum logic [2:0] {
      ST_FETCH  = 3'd0,
      ST_DECODE = 3'd1,
      ST_EXEC   = 3'd2,
      ST_WB     = 3'd3,
      ST_HALT   = 3'd4
   } state_e;

   typedef enum logic [2:0] {
      CLS_ILL,
      CLS_ADD,
      CLS_ADI,
      CLS_LHI,
      CLS_WWD,
      CLS_JMP,
      CLS_HLT
   } cls_e;

   localparam logic [OPC_W-1:0]  OPC_ADI   = OPC_W'(4);
   localparam logic [OPC_W-1:0]  OPC_LHI   = OPC_W'(6);
   localparam logic [OPC_W-1:0]  OPC_JMP   = OPC_W'(9);
   localparam logic [OPC_W-1:0]  OPC_RTYPE = OPC_W'(15);
   localparam logic [FUNC_W-1:0] FN_ADD    = FUNC_W'(0);
   localparam logic [FUNC_W-1:0] FN_WWD    = FUNC_W'(28);
   localparam logic [FUNC_W-1:0] FN_HLT    = FUNC_W'(29);

   if (OPC_W < 4 || FUNC_W < 5 || CNT_W < 1) begin : g_param_check
      $error("tsc_multicycle_ctrl: OPC_W>=4, FUNC_W>=5 and CNT_W>=1 are required");
   end

   state_e            r_state;
   state_e            w_state_next;
   logic [OPC_W-1:0]  r_opcode;
   logic [FUNC_W-1:0] r_func;
   logic              r_illegal;
   cls_e              w_cls;

   logic              w_advance;
   logic              w_ir;
   logic              w_pc;
   logic              w_rw;
   logic              w_opw;
   logic              w_set_illegal;
   logic              w_enter_halt;

   // Classification always works on the fields latched in FETCH, never the live bus.
   always_comb begin
      w_cls = CLS_ILL;
      if (r_opcode == OPC_ADI) begin
         w_cls = CLS_ADI;
      end else if (r_opcode == OPC_LHI) begin
         w_cls = CLS_LHI;
      end else if (r_opcode == OPC_JMP) begin
         w_cls = CLS_JMP;
      end else if (r_opcode == OPC_RTYPE) begin
         if (r_func == FN_ADD) begin
            w_cls = CLS_ADD;
         end else if (r_func == FN_WWD) begin
            w_cls = CLS_WWD;
         end else if (r_func == FN_HLT) begin
            w_cls = CLS_HLT;
         end
      end
   end

   assign w_advance = cpu_enable & ~reset_cpu;

   always_comb begin
      w_state_next  = r_state;
      w_ir          = 1'b0;
      w_pc          = 1'b0;
      w_rw          = 1'b0;
      w_opw         = 1'b0;
      w_set_illegal = 1'b0;
      w_enter_halt  = 1'b0;
      case (r_state)
         ST_FETCH: begin
            w_ir         = 1'b1;
            w_state_next = ST_DECODE;
         end
         ST_DECODE: begin
            if (w_cls == CLS_HLT) begin
               w_state_next = ST_HALT;
               w_enter_halt = 1'b1;
            end else begin
               w_state_next = ST_EXEC;
            end
         end
         ST_EXEC: begin
            case (w_cls)
               CLS_ADD, CLS_ADI, CLS_LHI: begin
                  w_state_next = ST_WB;
               end
               CLS_WWD: begin
                  w_opw        = wwd_enable;
                  w_pc         = 1'b1;
                  w_state_next = ST_FETCH;
               end
               CLS_JMP: begin
                  w_pc         = 1'b1;
                  w_state_next = ST_FETCH;
               end
               default: begin
                  // Unsupported encoding retires as a NOP so the program keeps moving.
                  w_set_illegal = 1'b1;
                  w_pc          = 1'b1;
                  w_state_next  = ST_FETCH;
               end
            endcase
         end
         ST_WB: begin
            w_rw         = 1'b1;
            w_pc         = 1'b1;
            w_state_next = ST_FETCH;
         end
         ST_HALT: begin
            w_state_next = ST_HALT;
         end
         default: begin
            w_state_next = ST_FETCH;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset_cpu) begin
         r_state   <= ST_FETCH;
         r_opcode  <= '0;
         r_func    <= '0;
         r_illegal <= 1'b0;
      end else if (cpu_enable) begin
         r_state <= w_state_next;
         if (r_state == ST_FETCH) begin
            r_opcode <= opcode;
            r_func   <= func;
         end
         if (w_set_illegal) begin
            r_illegal <= 1'b1;
         end
      end
   end

   assign ir_write          = w_ir  & w_advance;
   assign pc_write          = w_pc  & w_advance;
   assign reg_write         = w_rw  & w_advance;
   assign output_port_write = w_opw & w_advance;

   // Selects are steady from DECODE through WB so datapath muxes settle before the strobes fire.
   always_comb begin
      pc_src_jump = 1'b0;
      reg_dst_rd  = 1'b0;
      alu_src_imm = 1'b0;
      alu_op      = 2'b00;
      if (r_state == ST_DECODE || r_state == ST_EXEC || r_state == ST_WB) begin
         case (w_cls)
            CLS_ADD: begin
               reg_dst_rd = 1'b1;
            end
            CLS_ADI: begin
               alu_src_imm = 1'b1;
            end
            CLS_LHI: begin
               alu_src_imm = 1'b1;
               alu_op      = 2'b01;
            end
            CLS_JMP: begin
               pc_src_jump = 1'b1;
            end
            default: begin
               pc_src_jump = 1'b0;
            end
         endcase
      end
   end

   assign halted  = (r_state == ST_HALT);
   assign illegal = r_illegal;
   assign state   = r_state;

`ifdef INST_COUNT_EN
   logic [CNT_W-1:0] r_num_inst;

   always_ff @(posedge clk) begin
      if (reset_cpu) begin
         r_num_inst <= '0;
      end else if (pc_write || (w_enter_halt && w_advance)) begin
         r_num_inst <= r_num_inst + 1'b1;
      end
   end

   assign num_inst = r_num_inst;
`else
   logic w_enter_halt_unused;
   assign w_enter_halt_unused = w_enter_halt;
`endif

endmodule

// File: tb/tb_tsc_multicycle_ctrl.sv
// Table-driven bench for tsc_multicycle_ctrl plus hand-written HALT, reset and illegal sequences.
module tb_tsc_multicycle_ctrl;

   logic        clk = 1'b0;
   logic        reset_cpu = 1'b1;
   logic        cpu_enable = 1'b0;
   logic        wwd_enable = 1'b0;
   logic [3:0]  opcode = '0;
   logic [5:0]  func = '0;
   logic        ir_write, pc_write, pc_src_jump, reg_write, reg_dst_rd, alu_src_imm;
   logic [1:0]  alu_op;
   logic        output_port_write, halted, illegal;
   logic [2:0]  state;
`ifdef INST_COUNT_EN
   logic [15:0] num_inst;
`endif

   int n_checks = 0;
   int n_err    = 0;

   tsc_multicycle_ctrl dut (
      .clk               (clk),
      .reset_cpu         (reset_cpu),
      .cpu_enable        (cpu_enable),
      .wwd_enable        (wwd_enable),
      .opcode            (opcode),
      .func              (func),
      .ir_write          (ir_write),
      .pc_write          (pc_write),
      .pc_src_jump       (pc_src_jump),
      .reg_write         (reg_write),
      .reg_dst_rd        (reg_dst_rd),
      .alu_src_imm       (alu_src_imm),
      .alu_op            (alu_op),
      .output_port_write (output_port_write),
      .halted            (halted),
      .illegal           (illegal),
      .state             (state)
`ifdef INST_COUNT_EN
      ,
      .num_inst          (num_inst)
`endif
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        rst;
      logic        en;
      logic        wwd;
      logic [15:0] instr;
      logic [2:0]  st;
      logic [3:0]  stb;   // {ir_write, pc_write, reg_write, output_port_write}
      logic [4:0]  sel;   // {pc_src_jump, reg_dst_rd, alu_src_imm, alu_op}
      logic [1:0]  flg;   // {halted, illegal}
      int          cnt;
   } vec_t;

   localparam int NV = 32;
   vec_t vecs [0:NV-1];

   function automatic vec_t mk(input logic rst, input logic en, input logic wwd,
                               input logic [15:0] instr, input logic [2:0] st,
                               input logic [3:0] stb, input logic [4:0] sel,
                               input logic [1:0] flg, input int cnt);
      vec_t v;
      v.rst = rst; v.en = en; v.wwd = wwd; v.instr = instr;
      v.st = st; v.stb = stb; v.sel = sel; v.flg = flg; v.cnt = cnt;
      return v;
   endfunction

   function automatic logic [3:0] act_stb();
      return {ir_write, pc_write, reg_write, output_port_write};
   endfunction

   function automatic logic [4:0] act_sel();
      return {pc_src_jump, reg_dst_rd, alu_src_imm, alu_op};
   endfunction

   task automatic check(input string name, input int idx, input logic [15:0] act, input logic [15:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s [%0d]: got %h, expected %h", name, idx, act, exp);
      end
   endtask

   task automatic step(input logic rst, input logic en, input logic wwd, input logic [15:0] instr);
      @(negedge clk);
      reset_cpu  = rst;
      cpu_enable = en;
      wwd_enable = wwd;
      opcode     = instr[15:12];
      func       = instr[5:0];
      #1;
   endtask

   task automatic check_row(input string tag, input int idx, input logic [2:0] st,
                            input logic [3:0] stb, input logic [4:0] sel, input logic [1:0] flg);
      check({tag, "_state"}, idx, 16'(state), 16'(st));
      check({tag, "_strobes"}, idx, 16'(act_stb()), 16'(stb));
      check({tag, "_sel_flags"}, idx, {9'd0, act_sel(), halted, illegal}, {9'd0, sel, flg});
      $display("%s %0d: state=%0d stb=%b sel=%b halted=%b illegal=%b", tag, idx, state, act_stb(), act_sel(), halted, illegal);
   endtask

   int pc_pulses;

   initial begin
      // ADD F180
      vecs[0]  = mk(0, 1, 0, 16'hF180, 3'd0, 4'b1000, 5'b00000, 2'b00, 0);
      vecs[1]  = mk(0, 1, 0, 16'hF180, 3'd1, 4'b0000, 5'b01000, 2'b00, 0);
      vecs[2]  = mk(0, 1, 0, 16'hF180, 3'd2, 4'b0000, 5'b01000, 2'b00, 0);
      vecs[3]  = mk(0, 1, 0, 16'hF180, 3'd3, 4'b0110, 5'b01000, 2'b00, 0);
      // LHI 6101
      vecs[4]  = mk(0, 1, 0, 16'h6101, 3'd0, 4'b1000, 5'b00000, 2'b00, 1);
      vecs[5]  = mk(0, 1, 0, 16'h6101, 3'd1, 4'b0000, 5'b00101, 2'b00, 1);
      vecs[6]  = mk(0, 1, 0, 16'h6101, 3'd2, 4'b0000, 5'b00101, 2'b00, 1);
      vecs[7]  = mk(0, 1, 0, 16'h6101, 3'd3, 4'b0110, 5'b00101, 2'b00, 1);
      // ADI 4204
      vecs[8]  = mk(0, 1, 0, 16'h4204, 3'd0, 4'b1000, 5'b00000, 2'b00, 2);
      vecs[9]  = mk(0, 1, 0, 16'h4204, 3'd1, 4'b0000, 5'b00100, 2'b00, 2);
      vecs[10] = mk(0, 1, 0, 16'h4204, 3'd2, 4'b0000, 5'b00100, 2'b00, 2);
      vecs[11] = mk(0, 1, 0, 16'h4204, 3'd3, 4'b0110, 5'b00100, 2'b00, 2);
      // WWD F01C, port write disabled then enabled
      vecs[12] = mk(0, 1, 0, 16'hF01C, 3'd0, 4'b1000, 5'b00000, 2'b00, 3);
      vecs[13] = mk(0, 1, 0, 16'hF01C, 3'd1, 4'b0000, 5'b00000, 2'b00, 3);
      vecs[14] = mk(0, 1, 0, 16'hF01C, 3'd2, 4'b0100, 5'b00000, 2'b00, 3);
      vecs[15] = mk(0, 1, 1, 16'hF01C, 3'd0, 4'b1000, 5'b00000, 2'b00, 4);
      vecs[16] = mk(0, 1, 1, 16'hF01C, 3'd1, 4'b0000, 5'b00000, 2'b00, 4);
      vecs[17] = mk(0, 1, 1, 16'hF01C, 3'd2, 4'b0101, 5'b00000, 2'b00, 4);
      // JMP 9015 with cpu_enable low for three cycles in DECODE
      vecs[18] = mk(0, 1, 0, 16'h9015, 3'd0, 4'b1000, 5'b00000, 2'b00, 5);
      vecs[19] = mk(0, 0, 0, 16'h9015, 3'd1, 4'b0000, 5'b10000, 2'b00, 5);
      vecs[20] = mk(0, 0, 0, 16'h9015, 3'd1, 4'b0000, 5'b10000, 2'b00, 5);
      vecs[21] = mk(0, 0, 0, 16'h9015, 3'd1, 4'b0000, 5'b10000, 2'b00, 5);
      vecs[22] = mk(0, 1, 0, 16'h9015, 3'd1, 4'b0000, 5'b10000, 2'b00, 5);
      vecs[23] = mk(0, 1, 0, 16'h9015, 3'd2, 4'b0100, 5'b10000, 2'b00, 5);
      // ADD interrupted by reset in WB
      vecs[24] = mk(0, 1, 0, 16'hF180, 3'd0, 4'b1000, 5'b00000, 2'b00, 6);
      vecs[25] = mk(0, 1, 0, 16'hF180, 3'd1, 4'b0000, 5'b01000, 2'b00, 6);
      vecs[26] = mk(0, 1, 0, 16'hF180, 3'd2, 4'b0000, 5'b01000, 2'b00, 6);
      vecs[27] = mk(1, 1, 0, 16'hF180, 3'd3, 4'b0000, 5'b01000, 2'b00, 6);
      vecs[28] = mk(0, 0, 0, 16'hF01D, 3'd0, 4'b0000, 5'b00000, 2'b00, 0);
      // HLT F01D
      vecs[29] = mk(0, 1, 0, 16'hF01D, 3'd0, 4'b1000, 5'b00000, 2'b00, 0);
      vecs[30] = mk(0, 1, 0, 16'hF01D, 3'd1, 4'b0000, 5'b00000, 2'b00, 0);
      vecs[31] = mk(0, 1, 0, 16'hF01D, 3'd4, 4'b0000, 5'b00000, 2'b10, 1);

      repeat (2) @(posedge clk);

      for (int i = 0; i < NV; i++) begin
         step(vecs[i].rst, vecs[i].en, vecs[i].wwd, vecs[i].instr);
         check_row("vec", i, vecs[i].st, vecs[i].stb, vecs[i].sel, vecs[i].flg);
`ifdef INST_COUNT_EN
         check("vec_num_inst", i, num_inst, 16'(vecs[i].cnt));
`endif
      end

      // HALT is sticky under cpu_enable with arbitrary instruction words on the bus
      for (int i = 0; i < 20; i++) begin
         step(0, 1, 1, (i % 2 == 0) ? 16'hF180 : 16'h9015);
         check_row("halt", i, 3'd4, 4'b0000, 5'b00000, 2'b10);
      end
`ifdef INST_COUNT_EN
      check("halt_num_inst", 0, num_inst, 16'd1);
`endif

      // Reset out of HALT, then illegal opcode 7
      step(1, 1, 0, 16'h7000);
      check_row("rst_halt", 0, 3'd4, 4'b0000, 5'b00000, 2'b10);
      pc_pulses = 0;
      for (int i = 0; i < 3; i++) begin
         step(0, 1, 0, 16'h7000);
         check_row("ill", i, 3'(i), (i == 0) ? 4'b1000 : ((i == 2) ? 4'b0100 : 4'b0000), 5'b00000, 2'b00);
         if (pc_write === 1'b1) pc_pulses++;
      end
      step(0, 1, 0, 16'hF180);
      check_row("ill_done", 0, 3'd0, 4'b1000, 5'b00000, 2'b01);
      check("ill_pc_pulses", 0, 16'(pc_pulses), 16'd1);
`ifdef INST_COUNT_EN
      check("ill_num_inst", 0, num_inst, 16'd1);
`endif

      // Illegal flag survives a following legal ADD
      for (int i = 1; i < 4; i++) begin
         step(0, 1, 0, 16'hF180);
         check_row("sticky", i, 3'(i), (i == 3) ? 4'b0110 : 4'b0000, 5'b01000, 2'b01);
      end
      step(0, 1, 0, 16'hF180);
      check_row("sticky_end", 0, 3'd0, 4'b1000, 5'b00000, 2'b01);

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
